// File: rtl/dac_pkg.sv
// dac_pkg -- shared definitions for the DAC waveform generator.
//   CODE_W_DEFAULT : default DAC code width (DAC7611 is a 12-bit part)
//   CODE_MAX       : full-scale code at the default width
//   mode_t         : waveform select encoding used on the mode port
//   dir_t          : triangle sweep direction
package dac_pkg;

    localparam int CODE_W_DEFAULT = 12;
    localparam logic [CODE_W_DEFAULT-1:0] CODE_MAX = {CODE_W_DEFAULT{1'b1}};

    typedef enum logic [1:0] {
        MODE_SAW   = 2'd0,
        MODE_TRI   = 2'd1,
        MODE_SQR   = 2'd2,
        MODE_CONST = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/dac_tick_div.sv
// dac_tick_div -- programmable sample-rate divider.
//   clk      : clock, rising edge
//   rst_n    : synchronous active-low reset
//   clear    : synchronous clear (generator disabled); also masks tick
//   rate_div : terminal count; tick period is rate_div+1 cycles
//   tick     : high in the cycle the count equals rate_div
module dac_tick_div #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [DIV_W-1:0] rate_div,
    output logic             tick
);

    logic [DIV_W-1:0] count_reg;
    logic [DIV_W-1:0] count_next;

    assign tick = !clear && (count_reg == rate_div);

    // Using >= rather than == lets the counter recover immediately if
    // rate_div is lowered below the current count on the fly.
    always_comb begin
        count_next = count_reg + DIV_W'(1);
        if (count_reg >= rate_div) begin
            count_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/dac_wave_gen.sv
// dac_wave_gen -- waveform sample generator feeding a DAC serial driver.
//   clk_X4       : single clock, rising edge
//   rst_n        : synchronous active-low reset, highest priority
//   enable       : high runs the generator; low clears it synchronously
//   mode         : 0 saw, 1 triangle, 2 square, 3 constant
//   step         : phase increment per sample
//   rate_div     : sample period is rate_div+1 cycles
//   const_code   : output code in constant mode
//   sample_code  : code offered downstream, stable while sample_valid
//   sample_valid : valid half of the valid/ready handshake
//   sample_ready : downstream accepts when high together with sample_valid
//   wrap         : one-cycle pulse with the load of a post-wrap sample
//   overrun      : sticky, set when a tick finds the previous sample unsent
module dac_wave_gen
    import dac_pkg::*;
#(
    parameter int CODE_W = CODE_W_DEFAULT,
    parameter int DIV_W  = 16
) (
    input  logic              clk_X4,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [CODE_W-1:0] step,
    input  logic [DIV_W-1:0]  rate_div,
    input  logic [CODE_W-1:0] const_code,
    output logic [CODE_W-1:0] sample_code,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              wrap,
    output logic              overrun
);

    localparam logic [CODE_W-1:0] CODE_ALL_ONES = {CODE_W{1'b1}};

    logic              tick;
    logic              div_clear;
    logic              load;
    logic              transfer;
    logic              drop;

    logic [CODE_W-1:0] phase_reg,        phase_next;
    dir_t              dir_reg,          dir_next;
    logic              wrapped_reg,      wrapped_next;
    logic [CODE_W-1:0] sample_code_reg,  sample_code_next;
    logic              sample_valid_reg, sample_valid_next;
    logic              wrap_reg,         wrap_next;
    logic              overrun_reg,      overrun_next;

    logic [CODE_W:0]   phase_sum;
    logic [CODE_W-1:0] sqr_code;

    assign div_clear = !enable;

    dac_tick_div #(
        .DIV_W (DIV_W)
    ) u_tick_div (
        .clk      (clk_X4),
        .rst_n    (rst_n),
        .clear    (div_clear),
        .rate_div (rate_div),
        .tick     (tick)
    );

    // Handshake decode; everything below is registered so sample_ready
    // never reaches sample_code combinationally.
    assign transfer = sample_valid_reg && sample_ready;
    assign load     = tick && (!sample_valid_reg || sample_ready);
    assign drop     = tick && sample_valid_reg && !sample_ready;

    // Extra bit catches the carry out of the MSB (saw/square wrap,
    // triangle overshoot past full scale).
    assign phase_sum = {1'b0, phase_reg} + {1'b0, step};

    // Square output: every bit follows the phase MSB (full scale or zero).
    genvar gi;
    generate
        for (gi = 0; gi < CODE_W; gi++) begin : g_sqr
            assign sqr_code[gi] = phase_reg[CODE_W-1];
        end
    endgenerate

    // wrapped_reg marks that the current phase was produced by a wrap.
    // The wrap pulse is emitted when that phase is actually presented,
    // so it lines up with the first code of the new period.
    always_comb begin
        phase_next        = phase_reg;
        dir_next          = dir_reg;
        wrapped_next      = wrapped_reg;
        sample_code_next  = sample_code_reg;
        sample_valid_next = sample_valid_reg;
        wrap_next         = 1'b0;
        overrun_next      = overrun_reg;

        if (load) begin
            sample_valid_next = 1'b1;
            case (mode_t'(mode))
                MODE_SAW: begin
                    sample_code_next = phase_reg;
                    wrap_next        = wrapped_reg;
                    phase_next       = phase_sum[CODE_W-1:0];
                    wrapped_next     = phase_sum[CODE_W];
                end
                MODE_SQR: begin
                    sample_code_next = sqr_code;
                    wrap_next        = wrapped_reg;
                    phase_next       = phase_sum[CODE_W-1:0];
                    wrapped_next     = phase_sum[CODE_W];
                end
                MODE_TRI: begin
                    sample_code_next = phase_reg;
                    wrap_next        = wrapped_reg;
                    if (dir_reg == DIR_UP) begin
                        wrapped_next = 1'b0;
                        if (phase_sum[CODE_W]) begin
                            phase_next = CODE_ALL_ONES;
                            dir_next   = DIR_DOWN;
                        end else begin
                            phase_next = phase_sum[CODE_W-1:0];
                        end
                    end else begin
                        if (phase_reg < step) begin
                            phase_next   = '0;
                            dir_next     = DIR_UP;
                            wrapped_next = 1'b1;
                        end else begin
                            phase_next   = phase_reg - step;
                            wrapped_next = 1'b0;
                        end
                    end
                end
                default: begin
                    // Constant: phase and any pending wrap are left alone.
                    sample_code_next = const_code;
                end
            endcase
        end else if (transfer) begin
            sample_valid_next = 1'b0;
        end

        if (drop) begin
            overrun_next = 1'b1;
        end
    end

    always_ff @(posedge clk_X4) begin
        if (!rst_n) begin
            phase_reg        <= '0;
            dir_reg          <= DIR_UP;
            wrapped_reg      <= 1'b0;
            sample_code_reg  <= '0;
            sample_valid_reg <= 1'b0;
            wrap_reg         <= 1'b0;
            overrun_reg      <= 1'b0;
        end else if (!enable) begin
            // sample_code is left as-is; it is meaningless while invalid.
            phase_reg        <= '0;
            dir_reg          <= DIR_UP;
            wrapped_reg      <= 1'b0;
            sample_valid_reg <= 1'b0;
            wrap_reg         <= 1'b0;
            overrun_reg      <= 1'b0;
        end else begin
            phase_reg        <= phase_next;
            dir_reg          <= dir_next;
            wrapped_reg      <= wrapped_next;
            sample_code_reg  <= sample_code_next;
            sample_valid_reg <= sample_valid_next;
            wrap_reg         <= wrap_next;
            overrun_reg      <= overrun_next;
        end
    end

    assign sample_code  = sample_code_reg;
    assign sample_valid = sample_valid_reg;
    assign wrap         = wrap_reg;
    assign overrun      = overrun_reg;

endmodule

// File: tb/tb_dac_wave_gen.sv
// tb_dac_wave_gen -- directed, self-checking bench for dac_wave_gen.
// Expected samples are queued when a scenario is started; a monitor pops
// and compares one entry per valid/ready transfer (code, wrap seen since
// the previous transfer, and optionally the cycle gap between transfers).
module tb_dac_wave_gen;
    import dac_pkg::*;

    localparam int CW = 12;
    localparam int DW = 16;

    logic          clk_X4 = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [1:0]    mode;
    logic [CW-1:0] step;
    logic [DW-1:0] rate_div;
    logic [CW-1:0] const_code;
    logic [CW-1:0] sample_code;
    logic          sample_valid;
    logic          sample_ready;
    logic          wrap;
    logic          overrun;

    typedef struct {
        logic [CW-1:0] code;
        logic          wrap;
        int            gap;   // 0 = do not check spacing
    } exp_t;

    exp_t sb[$];
    int   total     = 0;
    int   bad       = 0;
    int   cyc       = 0;
    int   last_cyc  = 0;
    logic wrap_seen = 1'b0;

    dac_wave_gen #(
        .CODE_W (CW),
        .DIV_W  (DW)
    ) dut (
        .clk_X4       (clk_X4),
        .rst_n        (rst_n),
        .enable       (enable),
        .mode         (mode),
        .step         (step),
        .rate_div     (rate_div),
        .const_code   (const_code),
        .sample_code  (sample_code),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .wrap         (wrap),
        .overrun      (overrun)
    );

    always #5 clk_X4 = ~clk_X4;

    always @(posedge clk_X4) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [CW-1:0] c, input logic w, input int g);
        exp_t e;
        e.code = c;
        e.wrap = w;
        e.gap  = g;
        sb.push_back(e);
    endtask

    // Leaves the bench 1 time unit after a rising edge.
    task automatic cycles(input int n);
        repeat (n) @(posedge clk_X4);
        #1;
    endtask

    task automatic start(input logic [1:0] m, input logic [CW-1:0] s,
                         input logic [DW-1:0] rd, input logic rdy);
        mode         = m;
        step         = s;
        rate_div     = rd;
        sample_ready = rdy;
        enable       = 1'b1;
    endtask

    task automatic stop_gen();
        enable       = 1'b0;
        sample_ready = 1'b0;
    endtask

    // Cycles from the enabling edge until sample_valid is first seen.
    task automatic latency(input string tag, input int expv);
        int n;
        n = 0;
        do begin
            @(posedge clk_X4);
            #1;
            n++;
        end while (!sample_valid && n < 50);
        chk(tag, n, expv);
    endtask

    // Wait for the monitor to consume every queued sample, bounded.
    task automatic drain(input string tag, input int limit);
        int n;
        n = 0;
        while (sb.size() != 0 && n < limit) begin
            @(negedge clk_X4);
            #2;
            n++;
        end
        chk(tag, sb.size(), 0);
        sb.delete();
    endtask

    always @(negedge clk_X4) begin : mon
        exp_t e;
        if (!rst_n || !enable) begin
            wrap_seen = 1'b0;
        end else begin
            if (wrap) wrap_seen = 1'b1;
            if (sample_valid && sample_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_xfer", {20'd0, sample_code}, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    $display("xfer t=%0t code=%0d wrap=%0b (exp code=%0d wrap=%0b)",
                             $time, sample_code, wrap_seen, e.code, e.wrap);
                    chk("xfer_code", sample_code, e.code);
                    chk("xfer_wrap", wrap_seen, e.wrap);
                    if (e.gap != 0) chk("xfer_gap", cyc - last_cyc, e.gap);
                end
                wrap_seen = 1'b0;
                last_cyc  = cyc;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n        = 1'b0;
        enable       = 1'b0;
        mode         = MODE_SAW;
        step         = '0;
        rate_div     = '0;
        const_code   = '0;
        sample_ready = 1'b0;
        cycles(3);
        chk("rst_code",    sample_code,  0);
        chk("rst_valid",   sample_valid, 0);
        chk("rst_wrap",    wrap,         0);
        chk("rst_overrun", overrun,      0);
        rst_n = 1'b1;
        cycles(1);

        // Saw, step 1024, one sample every 4 cycles, wrap on 5th.
        push(12'd0, 0, 0); push(12'd1024, 0, 4); push(12'd2048, 0, 4);
        push(12'd3072, 0, 4); push(12'd0, 1, 4);
        start(MODE_SAW, 12'd1024, 16'd3, 1'b1);
        latency("saw_first_lat", 4);
        drain("saw_drain", 100);
        stop_gen();
        cycles(2);

        // Triangle, step 1500, a sample every cycle, wrap on 7th.
        push(12'd0, 0, 0);    push(12'd1500, 0, 1); push(12'd3000, 0, 1);
        push(CODE_MAX, 0, 1); push(12'd2595, 0, 1); push(12'd1095, 0, 1);
        push(12'd0, 1, 1);    push(12'd1500, 0, 1);
        start(MODE_TRI, 12'd1500, 16'd0, 1'b1);
        latency("tri_first_lat", 1);
        drain("tri_drain", 100);
        stop_gen();
        cycles(2);

        // Saw with downstream stalled: first code held, overrun, no advance.
        push(12'd0, 0, 0); push(12'd1, 0, 0);
        start(MODE_SAW, 12'd1, 16'd1, 1'b0);
        cycles(22);
        chk("stall_code",    sample_code,  0);
        chk("stall_valid",   sample_valid, 1);
        chk("stall_overrun", overrun,      1);
        sample_ready = 1'b1;
        drain("stall_drain", 20);
        chk("stall_overrun_sticky", overrun, 1);
        stop_gen();
        cycles(2);

        // Square, step 2048.
        push(12'd0, 0, 0); push(CODE_MAX, 0, 3); push(12'd0, 1, 3); push(CODE_MAX, 0, 3);
        start(MODE_SQR, 12'd2048, 16'd2, 1'b1);
        latency("sqr_first_lat", 3);
        drain("sqr_drain", 100);
        stop_gen();
        cycles(2);

        // Constant 0xABC with a nonzero step: no wrap.
        const_code = 12'hABC;
        push(12'hABC, 0, 0); push(12'hABC, 0, 2); push(12'hABC, 0, 2); push(12'hABC, 0, 2);
        start(MODE_CONST, 12'd1000, 16'd1, 1'b1);
        latency("const_first_lat", 2);
        drain("const_drain", 100);
        stop_gen();
        cycles(2);

        // step = 0: identical codes, no wrap.
        push(12'd0, 0, 0); push(12'd0, 0, 1); push(12'd0, 0, 1); push(12'd0, 0, 1);
        start(MODE_SAW, 12'd0, 16'd0, 1'b1);
        drain("step0_drain", 100);
        stop_gen();
        cycles(2);

        // Enable dropped mid-handshake clears valid and overrun.
        start(MODE_SAW, 12'd1, 16'd2, 1'b0);
        latency("ovr_first_lat", 3);
        cycles(9);
        chk("ovr_set",   overrun,      1);
        chk("ovr_valid", sample_valid, 1);
        enable = 1'b0;
        cycles(1);
        chk("dis_valid",   sample_valid, 0);
        chk("dis_overrun", overrun,      0);
        chk("dis_wrap",    wrap,         0);
        push(12'd0, 0, 0);
        start(MODE_SAW, 12'd1, 16'd2, 1'b1);
        latency("reen_lat", 3);
        drain("reen_drain", 50);
        stop_gen();
        cycles(2);

        // Reset mid-stream with enable high, then restart.
        push(12'd0, 0, 0); push(12'd1024, 0, 2);
        start(MODE_SAW, 12'd1024, 16'd1, 1'b1);
        latency("pre_rst_lat", 2);
        drain("pre_rst_drain", 50);
        rst_n = 1'b0;
        cycles(1);
        chk("mid_rst_code",    sample_code,  0);
        chk("mid_rst_valid",   sample_valid, 0);
        chk("mid_rst_wrap",    wrap,         0);
        chk("mid_rst_overrun", overrun,      0);
        push(12'd0, 0, 0);
        rst_n = 1'b1;
        latency("post_rst_lat", 2);
        drain("post_rst_drain", 50);
        stop_gen();
        cycles(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dac_wave_gen.md
DAC_WAVE_GEN -- requirements
Module: dac_wave_gen

Interface
REQ-001 SHALL have parameter CODE_W, default 12, DAC code width (DAC7611 resolution).
REQ-002 SHALL have parameter DIV_W, default 16, width of the sample-rate divider.
REQ-003 SHALL have port clk_X4, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port enable, input, 1, high enables generation; low synchronously clears the generator.
REQ-006 SHALL have port mode, input, 2: 0 saw, 1 triangle, 2 square, 3 constant.
REQ-007 SHALL have port step, input, CODE_W, phase increment per sample.
REQ-008 SHALL have port rate_div, input, DIV_W, sample period = rate_div+1 cycles.
REQ-009 SHALL have port const_code, input, CODE_W, output code in constant mode.
REQ-010 SHALL have port sample_code, output, CODE_W, code offered to the downstream DAC serial driver.
REQ-011 SHALL have port sample_valid, output, 1, sample_code is valid.
REQ-012 SHALL have port sample_ready, input, 1, downstream accepts; transfer when valid and ready are both high.
REQ-013 SHALL have port wrap, output, 1, one-cycle pulse at each period boundary.
REQ-014 SHALL have port overrun, output, 1, sticky flag for a dropped sample.

Function
REQ-015 Divider: counts 0..rate_div; tick is high in the cycle the count equals rate_div, then the count returns to 0. rate_div=0 gives a tick every cycle.
REQ-016 On tick with sample_valid low, or with a transfer in the same cycle, SHALL load sample_code from current phase/mode, set sample_valid, then advance the phase.
REQ-017 On tick with sample_valid high and sample_ready low: sample dropped, phase not advanced, overrun set.
REQ-018 sample_code SHALL be stable while sample_valid is high; sample_valid clears the cycle after a transfer unless reloaded per REQ-016.
REQ-019 Saw: code = phase; phase += step modulo 2^CODE_W.
REQ-020 Triangle: code = phase. Going up, if phase+step > max, phase = max and direction flips down. Going down, if phase < step, phase = 0 and direction flips up.
REQ-021 Square: code = max when the phase MSB is 1, else 0; the phase advances as in saw.
REQ-022 Constant: code = const_code; the phase is not advanced.
REQ-023 wrap SHALL pulse one cycle, coincident with the load, when a saw/square phase update carries out of the MSB or the triangle phase clamps to 0.
REQ-024 mode, step and const_code SHALL be sampled only at a load; a mode change does not reset the phase or direction.
REQ-025 step=0 SHALL produce a repeated identical code with no wrap.
REQ-026 First sample after enable rises SHALL be code 0 (const_code in constant mode), loaded at the first tick, rate_div+1 cycles after enable rises.
REQ-027 enable low SHALL clear divider, phase, direction (up), sample_valid, wrap and overrun, even mid-handshake.

Reset
REQ-028 rst_n low SHALL set divider 0, phase 0, direction up, sample_code 0, sample_valid 0, wrap 0, overrun 0.
REQ-029 Reset SHALL take priority over enable and all other inputs.

Structure
REQ-030 Package dac_pkg SHALL hold the mode encoding (MODE_SAW, MODE_TRI, MODE_SQR, MODE_CONST), the CODE_W default and CODE_MAX.
REQ-031 Divider SHALL be sub-module dac_tick_div (count, rate_div in, tick out, sync clear).
REQ-032 Phase/direction update SHALL be one registered stage; no combinational path from sample_ready to sample_code.

Verification
REQ-033 Saw, step=1024, rate_div=3, ready=1 -> codes 0,1024,2048,3072,0, one every 4 cycles; wrap with the 5th load.
REQ-034 Triangle, step=1500, rate_div=0, ready=1 -> 0,1500,3000,4095,2595,1095,0,1500; wrap at the 7th load.
REQ-035 Saw, step=1, ready=0 for 10 ticks -> code 0 held, overrun=1, phase unchanged; ready=1 -> next code 1.
REQ-036 Square, step=2048 -> codes 0,4095,0,4095; constant mode with const_code=0xABC -> 0xABC every tick, no wrap.
REQ-037 enable dropped while valid high and ready low -> next cycle valid=0, overrun=0; re-enable -> first code 0 after rate_div+1 cycles.
REQ-038 rst_n low mid-stream, with enable high -> all outputs 0 next cycle; release -> restart per REQ-026.
